// File: rtl/imm_extend_pipe.sv
// Two-stage pipelined RISC-V immediate extender with valid/ready handshake and flush.
// Optional macro IMM_ZEXT_EN enables the CSR zimm (src=5) zero-extended immediate.
module imm_extend_pipe #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_imm_src,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  localparam int unsigned ILEN = 32;
  localparam int unsigned SRCW = 3;

  localparam logic [SRCW-1:0] SRC_I = 3'd0;
  localparam logic [SRCW-1:0] SRC_S = 3'd1;
  localparam logic [SRCW-1:0] SRC_B = 3'd2;
  localparam logic [SRCW-1:0] SRC_U = 3'd3;
  localparam logic [SRCW-1:0] SRC_J = 3'd4;
`ifdef IMM_ZEXT_EN
  localparam logic [SRCW-1:0] SRC_Z = 3'd5;
`endif

  logic            v1;
  logic            v2;
  logic [ILEN-1:0] instr1;
  logic [SRCW-1:0] src1;
  logic [XLEN-1:0] imm2;
  logic            ill2;

  logic            ld1_c;
  logic            ld2_c;
  logic [ILEN-1:0] imm32_c;
  logic            ill_c;
  logic [XLEN-1:0] ext_c;
  logic            unused_opcode;

  // Opcode bits never contribute to any immediate.
  assign unused_opcode = ^instr1[6:0];

  assign in_ready = !v1 || !v2 || out_ready;
  assign ld1_c    = in_ready;
  assign ld2_c    = !v2 || out_ready;

  // Immediate extraction from the stage-1 instruction; bit 31 is always the sign.
  always_comb begin
    imm32_c = '0;
    ill_c   = 1'b0;
    case (src1)
      SRC_I: imm32_c = {{20{instr1[31]}}, instr1[31:20]};
      SRC_S: imm32_c = {{20{instr1[31]}}, instr1[31:25], instr1[11:7]};
      SRC_B: imm32_c = {{19{instr1[31]}}, instr1[31], instr1[7], instr1[30:25],
                        instr1[11:8], 1'b0};
      SRC_U: imm32_c = {instr1[31:12], 12'b0};
      SRC_J: imm32_c = {{11{instr1[31]}}, instr1[31], instr1[19:12], instr1[20],
                        instr1[30:21], 1'b0};
`ifdef IMM_ZEXT_EN
      SRC_Z: imm32_c = {27'b0, instr1[19:15]};
`endif
      default: ill_c = 1'b1;
    endcase
    ext_c = XLEN'($signed(imm32_c));
  end

  // Stage 1: capture raw instruction and select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      instr1 <= '0;
      src1   <= '0;
    end else if (flush) begin
      v1 <= 1'b0;
    end else if (ld1_c) begin
      v1 <= in_valid;
      if (in_valid) begin
        instr1 <= in_instr;
        src1   <= in_imm_src;
      end
    end
  end

  // Stage 2: capture extended immediate; held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      imm2 <= '0;
      ill2 <= 1'b0;
    end else if (flush) begin
      v2 <= 1'b0;
    end else if (ld2_c) begin
      v2 <= v1;
      if (v1) begin
        imm2 <= ext_c;
        ill2 <= ill_c;
      end
    end
  end

  assign out_valid   = v2;
  assign out_imm     = imm2;
  assign out_illegal = ill2;

endmodule
